hazard_controller: RTL and testbench

- Sequences the 5-stage pipeline around the ID-stage destination-register select (rt vs rd).
- Keeps a shadow copy of the destination register and its write/load flags for the EX, MEM and WB stages.
- From that state it drives the ID-stage operand forwarding selects, load-use stalls, branch flushes and whole-pipe freezes on data-memory wait.
- Sits beside the ID stage and feeds the PC, IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_controller.sv | 172 +++++++++++++++++
 tb/tb_hazard_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard control for a 5-stage pipeline: tracks destination registers of EX/MEM/WB,
// drives ID operand forwarding, load-use stalls, branch flushes and memory-wait freezes.
module hazard_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_regrt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [4:0]       id_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int unsigned RW = 5;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_STALL  = 2'b01,
    MODE_FREEZE = 2'b10
  } mode_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  logic [RW-1:0]    rs_c, rt_c, rd_c;
  logic             unused_c;
  mode_e            mode_c;
  logic             load_stall_c;
  logic             ex_wr_c, mem_wr_c;

  logic [RW-1:0]    ex_dest_q, ex_dest_d;
  logic             ex_wreg_q, ex_wreg_d;
  logic             ex_m2reg_q, ex_m2reg_d;
  logic [RW-1:0]    mem_dest_q, mem_dest_d;
  logic             mem_wreg_q, mem_wreg_d;
  logic             mem_m2reg_q, mem_m2reg_d;
  logic [RW-1:0]    wb_dest_q, wb_dest_d;
  logic             wb_wreg_q, wb_wreg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  assign rs_c     = id_instr[25:21];
  assign rt_c     = id_instr[20:16];
  assign rd_c     = id_instr[15:11];
  assign unused_c = ^{id_instr[31:26], id_instr[10:0], wb_dest_q, wb_wreg_q};
  assign id_dest  = id_regrt ? rt_c : rd_c;

  // A write to register 0 is architecturally discarded, so it never matches.
  assign ex_wr_c  = ex_wreg_q  && (ex_dest_q  != RW'(0));
  assign mem_wr_c = mem_wreg_q && (mem_dest_q != RW'(0));

  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] src,
    input logic          ex_wr,
    input logic [RW-1:0] ex_dest,
    input logic          ex_m2reg,
    input logic          mem_wr,
    input logic [RW-1:0] mem_dest,
    input logic          mem_m2reg
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_wr && (ex_dest == src) && !ex_m2reg)       sel = FWD_EX;
    else if (mem_wr && (mem_dest == src) && !mem_m2reg) sel = FWD_MEM;
    else if (mem_wr && (mem_dest == src) && mem_m2reg)  sel = FWD_LD;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(rs_c, ex_wr_c, ex_dest_q, ex_m2reg_q, mem_wr_c, mem_dest_q, mem_m2reg_q);
  assign fwd_b = fwd_sel(rt_c, ex_wr_c, ex_dest_q, ex_m2reg_q, mem_wr_c, mem_dest_q, mem_m2reg_q);

  assign load_stall_c = ex_wr_c && ex_m2reg_q &&
                        ((id_use_rs && (ex_dest_q == rs_c)) || (id_use_rt && (ex_dest_q == rt_c)));

  // Memory wait freezes everything; otherwise a load-use hazard bubbles ID/EX.
  always_comb begin
    mode_c = MODE_RUN;
    if (mem_busy)          mode_c = MODE_FREEZE;
    else if (load_stall_c) mode_c = MODE_STALL;
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_en      = 1'b1;
    ex_dest_d    = ex_dest_q;
    ex_wreg_d    = ex_wreg_q;
    ex_m2reg_d   = ex_m2reg_q;
    mem_dest_d   = mem_dest_q;
    mem_wreg_d   = mem_wreg_q;
    mem_m2reg_d  = mem_m2reg_q;
    wb_dest_d    = wb_dest_q;
    wb_wreg_d    = wb_wreg_q;
    stall_cnt_d  = stall_cnt_q;
    freeze_cnt_d = freeze_cnt_q;

    if (mode_c == MODE_FREEZE) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      pipe_en = 1'b0;
      if (freeze_cnt_q != {CNT_W{1'b1}}) freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
    end else begin
      mem_dest_d  = ex_dest_q;
      mem_wreg_d  = ex_wreg_q;
      mem_m2reg_d = ex_m2reg_q;
      wb_dest_d   = mem_dest_q;
      wb_wreg_d   = mem_wreg_q;
      if (mode_c == MODE_STALL) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        ex_dest_d   = id_dest;
        ex_wreg_d   = 1'b0;
        ex_m2reg_d  = 1'b0;
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        ifid_flush = id_branch_taken;
        ex_dest_d  = id_dest;
        ex_wreg_d  = id_wreg;
        ex_m2reg_d = id_m2reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dest_q    <= '0;
      ex_wreg_q    <= 1'b0;
      ex_m2reg_q   <= 1'b0;
      mem_dest_q   <= '0;
      mem_wreg_q   <= 1'b0;
      mem_m2reg_q  <= 1'b0;
      wb_dest_q    <= '0;
      wb_wreg_q    <= 1'b0;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      ex_dest_q    <= ex_dest_d;
      ex_wreg_q    <= ex_wreg_d;
      ex_m2reg_q   <= ex_m2reg_d;
      mem_dest_q   <= mem_dest_d;
      mem_wreg_q   <= mem_wreg_d;
      mem_m2reg_q  <= mem_m2reg_d;
      wb_dest_q    <= wb_dest_d;
      wb_wreg_q    <= wb_wreg_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use stall, freeze,
// branch flush, counter saturation (second instance with 2-bit counters), reset.
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_regrt, id_wreg, id_m2reg, id_use_rs, id_use_rt, id_branch_taken, mem_busy;

  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  id_dest;
  logic [15:0] stall_cnt, freeze_cnt;

  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_pipe_en;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [4:0]  s_id_dest;
  logic [1:0]  s_stall_cnt, s_freeze_cnt;

  logic [4:0]  ctl;
  int          n_cmp;
  int          n_bad;

  localparam logic [4:0] CTL_RUN    = 5'b11001;
  localparam logic [4:0] CTL_FLUSH  = 5'b11101;
  localparam logic [4:0] CTL_STALL  = 5'b00011;
  localparam logic [4:0] CTL_FREEZE = 5'b00000;

  assign ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en};

  hazard_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_regrt(id_regrt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_en(pipe_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .id_dest(id_dest),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
  );

  hazard_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_regrt(id_regrt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
    .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .pipe_en(s_pipe_en), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .id_dest(s_id_dest),
    .stall_cnt(s_stall_cnt), .freeze_cnt(s_freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic regrt, input logic wreg,
                       input logic m2reg, input logic urs, input logic urt,
                       input logic br, input logic busy);
    id_instr = instr; id_regrt = regrt; id_wreg = wreg; id_m2reg = m2reg;
    id_use_rs = urs; id_use_rt = urt; id_branch_taken = br; mem_busy = busy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain;
    repeat (3) nop();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_lw7;
    drive(i_type(6'h23, 5'd1, 5'd7), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_add8(input logic busy);
    drive(r_type(5'd7, 5'd7, 5'd8), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, busy);
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    n_cmp++; if ({stall_cnt, freeze_cnt} !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", {stall_cnt, freeze_cnt}); end
  endtask

  task automatic test_ex_forward;
    drain();
    drive(r_type(5'd1, 5'd2, 5'd3), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (id_dest !== 5'd3) begin n_bad++; $display("FAIL dest_rd: got %0d want 3", id_dest); end
    tick();
    drive(r_type(5'd3, 5'd5, 5'd4), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0100) begin n_bad++; $display("FAIL ex_fwd: got %b want 0100", {fwd_a, fwd_b}); end
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL ex_fwd_ctl: got %b want %b", ctl, CTL_RUN); end
    tick();
    drive(r_type(5'd1, 5'd2, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(r_type(5'd0, 5'd0, 5'd6), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL r0_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    tick();
  endtask

  task automatic test_load_use;
    drain();
    drive_lw7();
    n_cmp++; if (id_dest !== 5'd7) begin n_bad++; $display("FAIL dest_rt: got %0d want 7", id_dest); end
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL lw_ctl: got %b want %b", ctl, CTL_RUN); end
    tick();
    drive_add8(1'b0);
    n_cmp++; if (ctl !== CTL_STALL) begin n_bad++; $display("FAIL lu_stall: got %b want %b", ctl, CTL_STALL); end
    tick();
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL lu_release: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b1111) begin n_bad++; $display("FAIL lu_fwd: got %b want 1111", {fwd_a, fwd_b}); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_mem_forward;
    drain();
    drive(r_type(5'd1, 5'd2, 5'd9), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd11, 5'd12, 5'd10), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd9, 5'd9, 5'd13), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_bad++; $display("FAIL mem_fwd: got %b want 1010", {fwd_a, fwd_b}); end
    tick();
    drain();
    drive(r_type(5'd1, 5'd2, 5'd9), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd11, 5'd12, 5'd10), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd11, 5'd12, 5'd14), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd9, 5'd9, 5'd13), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL wb_nofwd: got %b want 0000", {fwd_a, fwd_b}); end
    tick();
    drain();
    drive(r_type(5'd1, 5'd2, 5'd9), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd3, 5'd4, 5'd9), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(r_type(5'd9, 5'd2, 5'd13), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0100) begin n_bad++; $display("FAIL ex_priority: got %b want 0100", {fwd_a, fwd_b}); end
    tick();
  endtask

  task automatic test_freeze;
    do_reset();
    drive_lw7(); tick();
    for (int i = 0; i < 3; i++) begin
      drive_add8(1'b1);
      n_cmp++; if (ctl !== CTL_FREEZE) begin n_bad++; $display("FAIL freeze_ctl%0d: got %b want %b", i, ctl, CTL_FREEZE); end
      tick();
    end
    n_cmp++; if (freeze_cnt !== 16'd3) begin n_bad++; $display("FAIL freeze_cnt: got %0d want 3", freeze_cnt); end
    drive_add8(1'b0);
    n_cmp++; if (ctl !== CTL_STALL) begin n_bad++; $display("FAIL post_freeze_stall: got %b want %b", ctl, CTL_STALL); end
    tick();
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL post_stall_run: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b1111) begin n_bad++; $display("FAIL post_stall_fwd: got %b want 1111", {fwd_a, fwd_b}); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL freeze_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_branch;
    drain();
    drive(i_type(6'h04, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL br_flush: got %b want %b", ctl, CTL_FLUSH); end
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL br_after: got %b want %b", ctl, CTL_RUN); end
    tick();
    drive_lw7(); tick();
    drive(i_type(6'h04, 5'd1, 5'd7), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (ctl !== CTL_STALL) begin n_bad++; $display("FAIL br_masked: got %b want %b", ctl, CTL_STALL); end
    tick();
    n_cmp++; if (ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL br_late_flush: got %b want %b", ctl, CTL_FLUSH); end
    n_cmp++; if (fwd_b !== 2'b11) begin n_bad++; $display("FAIL br_fwd_b: got %b want 11", fwd_b); end
    tick();
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_lw7(); tick();
      drive_add8(1'b0); tick();
      tick();
    end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL stall_cnt16: got %0d want 5", stall_cnt); end
    n_cmp++; if (s_stall_cnt !== 2'd3) begin n_bad++; $display("FAIL stall_sat: got %0d want 3", s_stall_cnt); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    n_cmp++; if (freeze_cnt !== 16'd5) begin n_bad++; $display("FAIL freeze_cnt16: got %0d want 5", freeze_cnt); end
    n_cmp++; if (s_freeze_cnt !== 2'd3) begin n_bad++; $display("FAIL freeze_sat: got %0d want 3", s_freeze_cnt); end
  endtask

  task automatic test_reset_in_freeze;
    drain();
    drive_lw7(); tick();
    drive_add8(1'b1); tick(); tick();
    rst = 1'b1;
    drive_add8(1'b1);
    tick();
    rst = 1'b0;
    drive_add8(1'b0);
    n_cmp++; if (ctl !== CTL_RUN) begin n_bad++; $display("FAIL rst_frz_ctl: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_bad++; $display("FAIL rst_frz_fwd: got %b want 0000", {fwd_a, fwd_b}); end
    n_cmp++; if ({stall_cnt, freeze_cnt} !== 32'h0) begin n_bad++; $display("FAIL rst_frz_cnt: got %h want 0", {stall_cnt, freeze_cnt}); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_mem_forward();
    test_freeze();
    test_branch();
    test_saturation();
    test_reset_in_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
